picosoc_mem_ctrl: RTL and testbench

//   Initiator-side controller for the picosoc_mem SRAM port. Accepts PicoRV32 native-bus requests
//   (valid/ready) and drives the SRAM's wen/addr/wdata lines. Captures the SRAM's 1-cycle-latency

---
 rtl/picosoc_mem_ctrl.sv | 159 +++++++++++++++
 tb/tb_picosoc_mem_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/picosoc_mem_ctrl.sv
// picosoc_mem_ctrl: initiator-side controller for one picosoc_mem SRAM.
// Turns PicoRV32 native-bus requests into registered SRAM wen/addr/wdata
// cycles. It captures the 1-cycle-latency SRAM read data for the CPU, and can
// zero-fill the whole SRAM after reset.
//
// Handshake: the CPU raises mem_valid and holds it, with address, data and
// strobes stable, until the block returns a single-cycle mem_ready pulse.
// mem_rdata is meaningful while mem_ready=1. A request outside the address
// window is never acknowledged. After every acknowledge there is one IDLE
// cycle before the next request is looked at.
module picosoc_mem_ctrl #(
    parameter int          WORDS          = 256,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        clr_busy,
    output logic [3:0]  ram_wen,
    output logic [21:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic [2:0]  dbg_state_o
);

    localparam int AW = $clog2(WORDS);
    localparam logic [AW-1:0] CNT_LAST = AW'(WORDS - 1);

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_IDLE  = 3'd1,
        S_WR    = 3'd2,
        S_RD    = 3'd3,
        S_RDW   = 3'd4,
        S_ACK   = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic           mem_ready_q, mem_ready_d;
    logic [31:0]    mem_rdata_q, mem_rdata_d;
    logic           clr_busy_q, clr_busy_d;
    logic [3:0]     ram_wen_q, ram_wen_d;
    logic [21:0]    ram_addr_q, ram_addr_d;
    logic [31:0]    ram_wdata_q, ram_wdata_d;

    logic           hit;
    logic [AW-1:0]  idx;

    // Address decode: upper bits select the window, the low byte offset is ignored.
    always_comb begin
        hit = (mem_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
        idx = mem_addr[AW+1:2];
    end

    // Next-state and registered-output logic; everything holds unless a state changes it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_ready_d = mem_ready_q;
        mem_rdata_d = mem_rdata_q;
        clr_busy_d  = clr_busy_q;
        ram_wen_d   = ram_wen_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;

        case (state_q)
            S_CLEAR: begin
                // One full-word zero write per cycle; the last one leaves for IDLE.
                ram_wen_d   = 4'hF;
                ram_addr_d  = 22'(cnt_q);
                ram_wdata_d = 32'h0;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    clr_busy_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_IDLE: begin
                ram_wen_d = 4'h0;
                if (mem_valid && hit) begin
                    ram_addr_d = 22'(idx);
                    if (mem_wstrb != 4'h0) begin
                        ram_wen_d   = mem_wstrb;
                        ram_wdata_d = mem_wdata;
                        state_d     = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_WR: begin
                // The SRAM takes the write on this edge; strobes go away right after.
                ram_wen_d   = 4'h0;
                mem_ready_d = 1'b1;
                state_d     = S_ACK;
            end
            S_RD: begin
                // The SRAM samples ram_addr at the end of this cycle.
                state_d = S_RDW;
            end
            S_RDW: begin
                mem_rdata_d = ram_rdata;
                mem_ready_d = 1'b1;
                state_d     = S_ACK;
            end
            S_ACK: begin
                mem_ready_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                ram_wen_d   = 4'h0;
                mem_ready_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops ram_wen at once so an unsampled write is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            cnt_q       <= '0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= 32'h0;
            clr_busy_q  <= CLEAR_ON_RESET;
            ram_wen_q   <= 4'h0;
            ram_addr_q  <= 22'h0;
            ram_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
            clr_busy_q  <= clr_busy_d;
            ram_wen_q   <= ram_wen_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // Output wiring.
    always_comb begin
        mem_ready   = mem_ready_q;
        mem_rdata   = mem_rdata_q;
        clr_busy    = clr_busy_q;
        ram_wen     = ram_wen_q;
        ram_addr    = ram_addr_q;
        ram_wdata   = ram_wdata_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_picosoc_mem_ctrl.sv
// Directed bench for picosoc_mem_ctrl with a behavioural picosoc_mem model.
module tb_picosoc_mem_ctrl;

    localparam int          WORDS = 256;
    localparam logic [31:0] BASE  = 32'h0001_0000;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        clr_busy;
    logic [3:0]  ram_wen;
    logic [21:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [2:0]  dbg_state;

    picosoc_mem_ctrl #(
        .WORDS          (WORDS),
        .BASE_ADDR      (BASE),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_rdata   (mem_rdata),
        .clr_busy    (clr_busy),
        .ram_wen     (ram_wen),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: byte-enabled write, 1-cycle read latency. Prefilled with a
    // nonzero pattern during the first reset so the zero-fill is visible.
    logic [31:0] sram [0:WORDS-1];
    logic        prefill;
    always @(posedge clk) begin
        if (prefill) begin
            for (int i = 0; i < WORDS; i++) sram[i] <= 32'hA5A5_0000 | i;
        end else begin
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) sram[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        ram_rdata <= sram[ram_addr[7:0]];
    end

    // SRAM write-cycle monitor
    int          wen_cycles = 0;
    logic [21:0] last_wen_addr = '0;
    logic [3:0]  last_wen = '0;
    always @(negedge clk) begin
        if (ram_wen != 4'h0) begin
            wen_cycles    = wen_cycles + 1;
            last_wen_addr = ram_addr;
            last_wen      = ram_wen;
        end
    end

    // scoreboard counters
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // driver: one bus transaction, returns data at mem_ready and edges to ready
    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, output logic [31:0] rdata,
                            output int lat);
        @(posedge clk); #1;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        lat   = 0;
        rdata = 32'h0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                lat = i;
                break;
            end
        end
        rdata     = mem_rdata;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        if (lat == 0) check("xfer_timeout", 32'd0, 32'd1);
    endtask

    // watch a zero-fill run that starts at the next edge
    task automatic watch_clear(input string tag);
        int  writes = 0;
        int  exp_addr = 0;
        int  ack_busy = 0;
        int  bad_wr = 0;
        bit  done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge clk); #1;
            if (ram_wen == 4'hF) begin
                if (ram_addr != 22'(exp_addr) || ram_wdata != 32'h0) bad_wr++;
                exp_addr++;
                writes++;
            end else if (ram_wen != 4'h0) begin
                bad_wr++;
            end
            if (mem_ready) ack_busy++;
            if (!clr_busy) done = 1'b1;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_writes"}, writes, WORDS);
        check({tag, "_bad_writes"}, bad_wr, 32'd0);
        check({tag, "_ack_while_busy"}, ack_busy, 32'd0);
    endtask

    logic [31:0] rd;
    int          lat;
    int          w0;
    int          acks;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        prefill   = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        // reset state
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_clr_busy", 32'(clr_busy), 32'd1);
        check("rst_ram_wen", 32'(ram_wen), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        rst     = 1'b0;
        prefill = 1'b0;

        // 1: zero-fill then reads of cleared words
        watch_clear("clr1");
        bus_xfer(BASE + 32'h000, 32'h0, 4'h0, rd, lat);
        check("clr1_rd_w0", rd, 32'h0);
        bus_xfer(BASE + 32'h190, 32'h0, 4'h0, rd, lat);
        check("clr1_rd_w100", rd, 32'h0);
        bus_xfer(BASE + 32'h3FC, 32'h0, 4'h0, rd, lat);
        check("clr1_rd_w255", rd, 32'h0);

        // 2: full word write and read back with latencies
        w0 = wen_cycles;
        bus_xfer(BASE + 32'h10, 32'h1234_5678, 4'hF, rd, lat);
        check("wr_latency", lat, 32'd2);
        check("wr_wen_cycles", wen_cycles - w0, 32'd1);
        check("wr_ram_addr", 32'(last_wen_addr), 32'd4);
        check("wr_ram_wen", 32'(last_wen), 32'hF);
        bus_xfer(BASE + 32'h10, 32'h0, 4'h0, rd, lat);
        check("rd_latency", lat, 32'd3);
        check("rd_data", rd, 32'h1234_5678);

        // 3: byte-lane write
        bus_xfer(BASE + 32'h10, 32'hAABB_CCDD, 4'b0100, rd, lat);
        check("bwr_rdata_hold", rd, 32'h1234_5678);
        bus_xfer(BASE + 32'h10, 32'h0, 4'h0, rd, lat);
        check("bwr_readback", rd, 32'h12BB_5678);

        // 4b: out-of-window write request is never served
        w0   = wen_cycles;
        acks = 0;
        @(posedge clk); #1;
        mem_valid = 1'b1;
        mem_addr  = BASE + 32'h400;
        mem_wdata = 32'hFFFF_FFFF;
        mem_wstrb = 4'hF;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (mem_ready) acks++;
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        check("miss_acks", acks, 32'd0);
        check("miss_wen_cycles", wen_cycles - w0, 32'd0);

        // 5: last word, no wrap onto word 0, byte offset ignored
        bus_xfer(BASE + 32'h000, 32'h1111_1111, 4'hF, rd, lat);
        check("hold_after_wr", rd, 32'h12BB_5678);
        bus_xfer(BASE + 32'h3FC, 32'hDEAD_BEEF, 4'hF, rd, lat);
        bus_xfer(BASE + 32'h000, 32'h0, 4'h0, rd, lat);
        check("wrap_w0", rd, 32'h1111_1111);
        bus_xfer(BASE + 32'h3FC, 32'h0, 4'h0, rd, lat);
        check("last_w255", rd, 32'hDEAD_BEEF);
        bus_xfer(BASE + 32'h3FF, 32'h0, 4'h0, rd, lat);
        check("offs3_w255", rd, 32'hDEAD_BEEF);

        // 6: reset while in WR
        bus_xfer(BASE + 32'h20, 32'h55AA_55AA, 4'hF, rd, lat);
        @(posedge clk); #1;
        mem_valid = 1'b1;
        mem_addr  = BASE + 32'h20;
        mem_wdata = 32'hFFFF_FFFF;
        mem_wstrb = 4'hF;
        @(posedge clk); #1;
        check("wr_state_wen", 32'(ram_wen), 32'hF);
        #2;
        rst       = 1'b1;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        #1;
        check("rst_wr_wen_drop", 32'(ram_wen), 32'd0);
        check("rst_wr_clr_busy", 32'(clr_busy), 32'd1);
        @(posedge clk); #1;
        check("rst_wr_word_kept", sram[8], 32'h55AA_55AA);

        // 4a: request held through the restarted zero-fill
        @(posedge clk); #1;
        rst       = 1'b0;
        mem_valid = 1'b1;
        mem_addr  = BASE + 32'h10;
        mem_wstrb = 4'h0;
        watch_clear("clr2");
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                lat = i;
                break;
            end
        end
        check("stall_rd_latency", lat, 32'd3);
        check("stall_rd_data", mem_rdata, 32'h0);
        mem_valid = 1'b0;
        bus_xfer(BASE + 32'h20, 32'h0, 4'h0, rd, lat);
        check("clr2_w8", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
